// File: rtl/afe_tdm_pkg.sv
// rtl/afe_tdm_pkg.sv - shared types, defaults and helpers for the AFE TDM frame mux
package afe_tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } tdm_state_e;

  localparam int DEF_N_MOD   = 8;
  localparam int DEF_DW      = 10;
  localparam int DEF_CH_W    = 6;
  localparam int DEF_OUT_DIV = 10;
  localparam int DEF_SYNC_CH = 2;

  localparam int OVR_CNT_W   = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Test-pattern word: slot index concatenated above the channel index.
  function automatic logic [31:0] tdm_pattern(input logic [31:0] idx,
                                              input logic [31:0] ch,
                                              input int          ch_w);
    return (idx << ch_w) | ch;
  endfunction

endpackage

// File: rtl/afe_tdm_slot_timer.sv
// rtl/afe_tdm_slot_timer.sv - word-slot divider and slot index counter for one TDM frame
module afe_tdm_slot_timer
  import afe_tdm_pkg::*;
#(
  parameter  int OUT_DIV = DEF_OUT_DIV,
  parameter  int N_MOD   = DEF_N_MOD,
  localparam int DIV_W   = cnt_w(OUT_DIV),
  localparam int IDX_W   = cnt_w(N_MOD)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             run,
  output logic [IDX_W-1:0] idx,
  output logic             strobe,
  output logic             slot_last,
  output logic             frame_last
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // frame_last marks the last slot of the frame; the frame ends when it coincides with slot_last.
  assign idx        = idx_q;
  assign strobe     = (div_q < DIV_W'(OUT_DIV / 2));
  assign slot_last  = (div_q == DIV_W'(OUT_DIV - 1));
  assign frame_last = (idx_q == IDX_W'(N_MOD - 1));

  // Advance the in-slot divider; step the slot index on each divider wrap.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (clear) begin
      div_d = '0;
      idx_d = '0;
    end else if (run) begin
      if (slot_last) begin
        div_d = '0;
        idx_d = frame_last ? '0 : idx_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/afe_tdm_frame_mux.sv
// rtl/afe_tdm_frame_mux.sv - A/B sample-pair capture, double buffer and TDM serialiser
// Build option AFE_TDM_TEST_PATTERN_EN: emitted words become {idx, ch} and its inverse.
module afe_tdm_frame_mux
  import afe_tdm_pkg::*;
#(
  parameter int N_MOD   = DEF_N_MOD,
  parameter int DW      = DEF_DW,
  parameter int CH_W    = DEF_CH_W,
  parameter int OUT_DIV = DEF_OUT_DIV,
  parameter int SYNC_CH = DEF_SYNC_CH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 smp_valid,
  input  logic [CH_W-1:0]      smp_ch,
  input  logic [N_MOD*DW-1:0]  smp_a,
  input  logic [N_MOD*DW-1:0]  smp_b,
  output logic [DW-1:0]        data_out_a,
  output logic [DW-1:0]        data_out_b,
  output logic                 data_out_clk,
  output logic                 sync,
  output logic                 busy,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt
);

  localparam int IDX_W = cnt_w(N_MOD);

  tdm_state_e state_q, state_d;

  logic [DW-1:0]   hold_a_q [N_MOD];
  logic [DW-1:0]   hold_b_q [N_MOD];
  logic [DW-1:0]   out_a_q  [N_MOD];
  logic [DW-1:0]   out_b_q  [N_MOD];
  logic [CH_W-1:0] hold_ch_q, out_ch_q;
  logic            pend_q;
  logic            overrun_q;
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  logic [IDX_W-1:0] idx;
  logic             strobe, slot_last, frame_last;
  logic             tmr_clear, tmr_run, xfer;

  logic [DW-1:0] a_d, b_d, a_q, b_q;
  logic          clk_d, sync_d, busy_d;
  logic          clk_q, sync_q, busy_q;

  afe_tdm_slot_timer #(
    .OUT_DIV (OUT_DIV),
    .N_MOD   (N_MOD)
  ) u_slot_timer (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (tmr_clear),
    .run        (tmr_run),
    .idx        (idx),
    .strobe     (strobe),
    .slot_last  (slot_last),
    .frame_last (frame_last)
  );

  // Next state, hold->out transfer decision and next output values.
  always_comb begin
    state_d   = state_q;
    xfer      = 1'b0;
    tmr_clear = 1'b0;
    tmr_run   = 1'b0;
    a_d       = '0;
    b_d       = '0;
    clk_d     = 1'b0;
    sync_d    = 1'b0;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (pend_q) begin
          xfer    = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        tmr_run = 1'b1;
        busy_d  = 1'b1;
`ifdef AFE_TDM_TEST_PATTERN_EN
        a_d = DW'(tdm_pattern(32'(idx), 32'(out_ch_q), CH_W));
        b_d = ~a_d;
`else
        a_d = out_a_q[idx];
        b_d = out_b_q[idx];
`endif
        clk_d  = strobe;
        sync_d = (idx == '0) && (out_ch_q == CH_W'(SYNC_CH));
        // End of frame: reload back-to-back if another set is waiting.
        if (slot_last && frame_last) begin
          if (pend_q) begin
            xfer = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold/out banks, pending flag and overrun bookkeeping; a new capture always wins the hold bank.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int m = 0; m < N_MOD; m++) begin
        hold_a_q[m] <= '0;
        hold_b_q[m] <= '0;
        out_a_q[m]  <= '0;
        out_b_q[m]  <= '0;
      end
      hold_ch_q <= '0;
      out_ch_q  <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      if (xfer) begin
        for (int m = 0; m < N_MOD; m++) begin
          out_a_q[m] <= hold_a_q[m];
          out_b_q[m] <= hold_b_q[m];
        end
        out_ch_q <= hold_ch_q;
      end
      if (smp_valid) begin
        for (int m = 0; m < N_MOD; m++) begin
          hold_a_q[m] <= smp_a[m*DW +: DW];
          hold_b_q[m] <= smp_b[m*DW +: DW];
        end
        hold_ch_q <= smp_ch;
        pend_q    <= 1'b1;
        if (pend_q && !xfer) begin
          overrun_q <= 1'b1;
          if (ovr_cnt_q != '1) begin
            ovr_cnt_q <= ovr_cnt_q + 1'b1;
          end
        end
      end else if (xfer) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Output registers: every pin is a flop, so nothing on smp_* reaches the outputs combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      b_q    <= '0;
      clk_q  <= 1'b0;
      sync_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      clk_q  <= clk_d;
      sync_q <= sync_d;
      busy_q <= busy_d;
    end
  end

  assign data_out_a   = a_q;
  assign data_out_b   = b_q;
  assign data_out_clk = clk_q;
  assign sync         = sync_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign overrun_cnt  = ovr_cnt_q;

endmodule
